// File: rtl/bus_pkg.sv
// Shared types and constants for the single-outstanding bus master.
package bus_pkg;

  localparam int BUS_DATA_W = 32;
  localparam int BUS_ADDR_W = 32;

  localparam logic BUS_CMD_READ  = 1'b0;
  localparam logic BUS_CMD_WRITE = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2,
    GAP  = 2'd3
  } bus_state_e;

endpackage

// File: rtl/bus_master_ctrl.sv
// Single-outstanding bus master: takes one command from the upstream
// valid/ready port, runs the req/ack handshake with the slave and returns
// the result on the response port.
// Optional request timeout: define BUS_MASTER_CTRL_TIMEOUT_EN.
module bus_master_ctrl
  import bus_pkg::*;
#(
  parameter int DATA_W         = BUS_DATA_W,
  parameter int ADDR_W         = BUS_ADDR_W,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_we,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              req,
  output logic              cmd,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] wdata,
  input  logic              ack,
  input  logic [DATA_W-1:0] rdata
);

  // A one-cycle timeout window would abort before the slave could ever ack.
  if (TIMEOUT_CYCLES < 2) begin : g_bad_cfg
    $error("bus_master_ctrl: TIMEOUT_CYCLES must be at least 2");
  end

  bus_state_e        r_state, w_state_nxt;
  logic              r_req, w_req_nxt;
  logic              r_cmd, w_cmd_nxt;
  logic [ADDR_W-1:0] r_addr, w_addr_nxt;
  logic [DATA_W-1:0] r_wdata, w_wdata_nxt;
  logic              r_resp_valid, w_resp_valid_nxt;
  logic [DATA_W-1:0] r_resp_rdata, w_resp_rdata_nxt;
  logic              r_resp_err, w_resp_err_nxt;

`ifdef BUS_MASTER_CTRL_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
`endif

  // Ready only while idle; held low during reset so nothing is taken then.
  assign cmd_ready = (r_state == IDLE) && rst;

  assign req        = r_req;
  assign cmd        = r_cmd;
  assign addr       = r_addr;
  assign wdata      = r_wdata;
  assign resp_valid = r_resp_valid;
  assign resp_rdata = r_resp_rdata;
  assign resp_err   = r_resp_err;

  // Next-state and next-output decode for the transaction FSM.
  always_comb begin
    // NOTE: every target gets a default first so no path can infer a latch.
    w_state_nxt      = r_state;
    w_req_nxt        = r_req;
    w_cmd_nxt        = r_cmd;
    w_addr_nxt       = r_addr;
    w_wdata_nxt      = r_wdata;
    w_resp_valid_nxt = r_resp_valid;
    w_resp_rdata_nxt = r_resp_rdata;
    w_resp_err_nxt   = r_resp_err;
`ifdef BUS_MASTER_CTRL_TIMEOUT_EN
    w_cnt_nxt        = r_cnt;
`endif
    case (r_state)
      IDLE: begin
        if (cmd_valid) begin
          w_cmd_nxt   = cmd_we;
          w_addr_nxt  = cmd_addr;
          w_wdata_nxt = cmd_wdata;
          w_req_nxt   = 1'b1;
          w_state_nxt = REQ;
`ifdef BUS_MASTER_CTRL_TIMEOUT_EN
          w_cnt_nxt   = '0;
`endif
        end
      end
      REQ: begin
        // An ack in the final timeout cycle still completes normally.
        if (ack) begin
          w_req_nxt        = 1'b0;
          w_resp_rdata_nxt = (r_cmd == BUS_CMD_WRITE) ? '0 : rdata;
          w_resp_err_nxt   = 1'b0;
          w_resp_valid_nxt = 1'b1;
          w_state_nxt      = RESP;
        end
`ifdef BUS_MASTER_CTRL_TIMEOUT_EN
        else if (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          w_req_nxt        = 1'b0;
          w_resp_rdata_nxt = '0;
          w_resp_err_nxt   = 1'b1;
          w_resp_valid_nxt = 1'b1;
          w_state_nxt      = RESP;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
`endif
      end
      RESP: begin
        if (resp_ready) begin
          w_resp_valid_nxt = 1'b0;
          w_state_nxt      = GAP;
        end
      end
      GAP: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // State and registered outputs, with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      // NOTE: all control and datapath registers are reset; there is no memory here.
      r_state      <= IDLE;
      r_req        <= 1'b0;
      r_cmd        <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= '0;
      r_resp_err   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      r_state      <= w_state_nxt;
      r_req        <= w_req_nxt;
      r_cmd        <= w_cmd_nxt;
      r_addr       <= w_addr_nxt;
      r_wdata      <= w_wdata_nxt;
      r_resp_valid <= w_resp_valid_nxt;
      r_resp_rdata <= w_resp_rdata_nxt;
      r_resp_err   <= w_resp_err_nxt;
    end
  end

`ifdef BUS_MASTER_CTRL_TIMEOUT_EN
  // Cycles spent in REQ without an ack.
  always_ff @(posedge clk) begin
    if (!rst) r_cnt <= '0;
    else      r_cnt <= w_cnt_nxt;
  end
`endif

endmodule

// File: tb/tb_bus_master_ctrl.sv
// Directed self-checking bench for bus_master_ctrl. The slave side is driven
// by hand: ack is raised the cycle after req has been sampled.
module tb_bus_master_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_we;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        req;
  logic        cmd;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        ack;
  logic [31:0] rdata;

  int n_checks = 0;
  int n_fail   = 0;

  bus_master_ctrl #(
    .DATA_W        (32),
    .ADDR_W        (32),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_we    (cmd_we),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_rdata(resp_rdata),
    .resp_err  (resp_err),
    .req       (req),
    .cmd       (cmd),
    .addr      (addr),
    .wdata     (wdata),
    .ack       (ack),
    .rdata     (rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst        = 1'b0;
    cmd_valid  = 1'b1;
    cmd_we     = 1'b0;
    cmd_addr   = 32'h0;
    cmd_wdata  = 32'h0;
    resp_ready = 1'b0;
    ack        = 1'b0;
    rdata      = 32'h0;

    // ---- reset held 3 cycles with cmd_valid high ----
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_req",        32'(req),        32'h0);
      check("rst_resp_valid", 32'(resp_valid), 32'h0);
      check("rst_cmd_ready",  32'(cmd_ready),  32'h0);
    end
    check("rst_addr",       addr,            32'h0);
    check("rst_wdata",      wdata,           32'h0);
    check("rst_resp_rdata", resp_rdata,      32'h0);
    check("rst_resp_err",   32'(resp_err),   32'h0);
    cmd_valid = 1'b0;
    rst       = 1'b1;
    #1;
    check("post_rst_cmd_ready", 32'(cmd_ready), 32'h1);

    // ---- stray ack while idle is ignored ----
    ack = 1'b1;
    tick();
    ack = 1'b0;
    check("idle_ack_resp_valid", 32'(resp_valid), 32'h0);
    check("idle_ack_cmd_ready",  32'(cmd_ready),  32'h1);
    check("idle_ack_req",        32'(req),        32'h0);

    // ---- read 0x10 -> 0x5 ----
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 32'h10; cmd_wdata = 32'h1234;
    tick();
    cmd_valid = 1'b0;
    check("rd_req_rise",   32'(req),        32'h1);
    check("rd_cmd",        32'(cmd),        32'h0);
    check("rd_addr",       addr,            32'h10);
    check("rd_cmd_ready",  32'(cmd_ready),  32'h0);
    check("rd_no_resp",    32'(resp_valid), 32'h0);
    tick();
    check("rd_req_held",   32'(req),        32'h1);
    ack = 1'b1; rdata = 32'h5;
    tick();
    ack = 1'b0; rdata = 32'h0;
    check("rd_req_fall",   32'(req),        32'h0);
    check("rd_resp_valid", 32'(resp_valid), 32'h1);
    check("rd_resp_rdata", resp_rdata,      32'h5);
    check("rd_resp_err",   32'(resp_err),   32'h0);
    resp_ready = 1'b1;
    tick();
    check("rd_resp_drop",  32'(resp_valid), 32'h0);
    check("rd_gap_ready",  32'(cmd_ready),  32'h0);
    tick();
    resp_ready = 1'b0;
    check("rd_idle_ready", 32'(cmd_ready),  32'h1);

    // ---- write 0x20 <- 0xDEADBEEF ----
    cmd_valid = 1'b1; cmd_we = 1'b1; cmd_addr = 32'h20; cmd_wdata = 32'hDEADBEEF;
    tick();
    cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = 32'h0; cmd_wdata = 32'h0;
    for (int i = 0; i < 2; i++) begin
      check("wr_req",   32'(req), 32'h1);
      check("wr_cmd",   32'(cmd), 32'h1);
      check("wr_addr",  addr,     32'h20);
      check("wr_wdata", wdata,    32'hDEADBEEF);
      if (i == 0) tick();
    end
    ack = 1'b1; rdata = 32'hFFFFFFFF;
    tick();
    ack = 1'b0; rdata = 32'h0;
    check("wr_req_fall",   32'(req),        32'h0);
    check("wr_resp_valid", 32'(resp_valid), 32'h1);
    check("wr_resp_rdata", resp_rdata,      32'h0);
    check("wr_resp_err",   32'(resp_err),   32'h0);
    resp_ready = 1'b1;
    tick();
    tick();
    resp_ready = 1'b0;
    check("wr_idle_ready", 32'(cmd_ready),  32'h1);

    // ---- backpressure with a second read queued ----
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 32'h30;
    tick();
    cmd_addr = 32'h40;                 // next command already queued
    check("bp_req1",       32'(req), 32'h1);
    check("bp_addr1",      addr,     32'h30);
    tick();
    ack = 1'b1; rdata = 32'hA5A5A5A5;
    tick();
    ack = 1'b0; rdata = 32'h0;
    check("bp_resp_valid", 32'(resp_valid), 32'h1);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("bp_hold_valid", 32'(resp_valid), 32'h1);
      check("bp_hold_rdata", resp_rdata,      32'hA5A5A5A5);
      check("bp_hold_ready", 32'(cmd_ready),  32'h0);
      check("bp_hold_req",   32'(req),        32'h0);
    end
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    check("bp_gap_valid",  32'(resp_valid), 32'h0);
    check("bp_gap_ready",  32'(cmd_ready),  32'h0);
    check("bp_gap_req",    32'(req),        32'h0);
    tick();
    check("bp_idle_ready", 32'(cmd_ready),  32'h1);
    check("bp_idle_req",   32'(req),        32'h0);
    tick();
    cmd_valid = 1'b0;
    check("bp_req2",       32'(req), 32'h1);
    check("bp_addr2",      addr,     32'h40);
    tick();
    ack = 1'b1; rdata = 32'h0000BEEF;
    tick();
    ack = 1'b0; rdata = 32'h0;
    check("bp_resp2_valid", 32'(resp_valid), 32'h1);
    check("bp_resp2_rdata", resp_rdata,      32'h0000BEEF);
    resp_ready = 1'b1;
    tick();
    tick();
    resp_ready = 1'b0;

    // ---- reset in the middle of a request ----
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 32'h50;
    tick();
    cmd_valid = 1'b0;
    check("mr_req_before", 32'(req), 32'h1);
    rst = 1'b0;
    tick();
    check("mr_req_cut",    32'(req),        32'h0);
    check("mr_no_resp",    32'(resp_valid), 32'h0);
    rst = 1'b1;
    ack = 1'b1;                        // late ack lands in IDLE
    tick();
    ack = 1'b0;
    check("mr_late_ack_resp",  32'(resp_valid), 32'h0);
    check("mr_late_ack_ready", 32'(cmd_ready),  32'h1);
    cmd_valid = 1'b1; cmd_addr = 32'h60;
    tick();
    cmd_valid = 1'b0;
    check("mr_fresh_req",  32'(req), 32'h1);
    check("mr_fresh_addr", addr,     32'h60);
    tick();
    ack = 1'b1; rdata = 32'h77;
    tick();
    ack = 1'b0; rdata = 32'h0;
    check("mr_fresh_valid", 32'(resp_valid), 32'h1);
    check("mr_fresh_rdata", resp_rdata,      32'h77);
    check("mr_fresh_err",   32'(resp_err),   32'h0);
    resp_ready = 1'b1;
    tick();
    tick();
    resp_ready = 1'b0;

    // ---- slave never acks ----
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 32'h70;
    tick();
    cmd_valid = 1'b0;
`ifdef BUS_MASTER_CTRL_TIMEOUT_EN
    // TIMEOUT_CYCLES=4: req high for exactly four REQ cycles.
    for (int i = 0; i < 3; i++) begin
      check("to_req_high", 32'(req),        32'h1);
      check("to_no_resp",  32'(resp_valid), 32'h0);
      tick();
    end
    check("to_req_last", 32'(req), 32'h1);
    tick();
    check("to_req_fall",   32'(req),        32'h0);
    check("to_resp_valid", 32'(resp_valid), 32'h1);
    check("to_resp_err",   32'(resp_err),   32'h1);
    check("to_resp_rdata", resp_rdata,      32'h0);
`else
    // Without the timeout, REQ waits for ack indefinitely.
    for (int i = 0; i < 8; i++) begin
      check("nto_req_high", 32'(req),        32'h1);
      check("nto_no_resp",  32'(resp_valid), 32'h0);
      tick();
    end
    ack = 1'b1; rdata = 32'h99;
    tick();
    ack = 1'b0; rdata = 32'h0;
    check("nto_resp_valid", 32'(resp_valid), 32'h1);
    check("nto_resp_err",   32'(resp_err),   32'h0);
    check("nto_resp_rdata", resp_rdata,      32'h99);
`endif
    resp_ready = 1'b1;
    tick();
    check("end_resp_drop", 32'(resp_valid), 32'h0);
    tick();
    check("end_idle_ready", 32'(cmd_ready), 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
